// File: rtl/full_adder_bist.sv
// full_adder_bist: self-test controller that sweeps all 8 full-adder input vectors and checks the responses
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   rst            in   asynchronous active-high reset
//   start          in   run request; honoured only in IDLE
//   a/b/carry_in   out  registered stimulus = vector index bits 2/1/0 (0 outside APPLY)
//   sum/carry_out  in   adder response, sampled at the last settle cycle of each vector
//   busy           out  high while vectors are being applied
//   done           out  one-cycle end-of-run pulse
//   pass           out  run result, valid from done until the next accepted start
//   err_count      out  mismatching vectors, saturating at 255
//   fail_seen      out  at least one mismatch this run
//   first_fail_vec out  {a,b,carry_in} of the first mismatch
//
// Parameters: SETTLE_CYCLES (>=1) hold cycles per vector, LOOPS (>=1) sweeps per run.
// Macro FA_BIST_ABORT_ON_FAIL_EN: when defined, the first mismatch ends the run.
module full_adder_bist #(
   parameter int SETTLE_CYCLES = 1,
   parameter int LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       carry_in,
   input  logic       sum,
   input  logic       carry_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic       fail_seen,
   output logic [2:0] first_fail_vec
);
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
   state_t        state_q;
   logic [2:0]    idx_q;
   logic [SW-1:0] settle_q;
   logic [LW-1:0] loop_q;
   logic          busy_q, done_q, pass_q, fail_q;
   logic [7:0]    err_q, err_d;
   logic [2:0]    ffv_q, ffv_d;
   logic          cmp, mis, fail_d, abort, finish;
   assign {a, b, carry_in} = idx_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign fail_seen        = fail_q;
   assign first_fail_vec   = ffv_q;
   // The index register doubles as the stimulus register, so the response
   // is checked against exactly the vector currently on the adder inputs.
   always_comb begin
      cmp    = state_q == APPLY && settle_q == SW'(SETTLE_CYCLES - 1);
      mis    = (sum != ^idx_q) ||
               (carry_out != ((idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0])));
      err_d  = cmp && mis && err_q != 8'hff ? err_q + 8'd1 : err_q;
      fail_d = fail_q | (cmp & mis);
      ffv_d  = cmp && mis && !fail_q ? idx_q : ffv_q;
`ifdef FA_BIST_ABORT_ON_FAIL_EN
      abort  = mis;
`else
      abort  = 1'b0;
`endif
      finish = cmp && ((idx_q == 3'd7 && loop_q == LW'(LOOPS - 1)) || abort);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         loop_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fail_q   <= 1'b0;
         ffv_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q  <= APPLY;
               busy_q   <= 1'b1;
               idx_q    <= '0;
               settle_q <= '0;
               loop_q   <= '0;
               pass_q   <= 1'b0;
               err_q    <= '0;
               fail_q   <= 1'b0;
               ffv_q    <= '0;
            end
            APPLY: begin
               err_q  <= err_d;
               fail_q <= fail_d;
               ffv_q  <= ffv_d;
               if (!cmp) settle_q <= settle_q + SW'(1);
               else begin
                  settle_q <= '0;
                  if (finish) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= !fail_d;
                     idx_q   <= '0;
                  end else begin
                     idx_q  <= idx_q + 3'd1;
                     loop_q <= loop_q + LW'(idx_q == 3'd7);
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: directed checks of the adder BIST against hand-computed results
module tb_full_adder_bist;
   logic clk = 1'b0, rst = 1'b1, start1 = 1'b0, start2 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic a1, b1, c1, s1, co1, busy1, done1, pass1, fail1;
   logic a2, b2, c2, s2, co2, busy2, done2, pass2, fail2;
   logic [7:0] err1, err2;
   logic [2:0] ffv1, ffv2;
   int total = 0, bad = 0, n;
   always #5 clk = ~clk;
   // adder model with injectable faults: 1 = sum stuck-at-0, 2 = carry_out inverted
   assign s1  = mode == 2'd1 ? 1'b0 : a1 ^ b1 ^ c1;
   assign co1 = ((a1 & b1) | (a1 & c1) | (b1 & c1)) ^ (mode == 2'd2);
   assign s2  = mode == 2'd1 ? 1'b0 : a2 ^ b2 ^ c2;
   assign co2 = ((a2 & b2) | (a2 & c2) | (b2 & c2)) ^ (mode == 2'd2);
   full_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(c1),
      .sum(s1), .carry_out(co1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_seen(fail1), .first_fail_vec(ffv1));
   full_adder_bist #(.SETTLE_CYCLES(3), .LOOPS(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .carry_in(c2),
      .sum(s2), .carry_out(co2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_seen(fail2), .first_fail_vec(ffv2));
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // pulse start on one instance and count edges after the start edge until done
   task automatic run(input bit sel, output int edges);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      start2 = 1'b0;
      edges = 0;
      while (!(sel ? done2 : done1) && edges < 500) begin
         @(posedge clk);
         #1 edges++;
      end
   endtask
   initial begin
      @(posedge clk);
      #1 chk("reset_outs", {a1, b1, c1, busy1, done1, pass1, err1, fail1, ffv1}, 0);
      rst = 1'b0;
      // clean sweep with per-cycle stimulus check
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      chk("v0", {a1, b1, c1}, 0);
      chk("busy_on", busy1, 1);
      for (int k = 1; k < 8; k++) begin
         @(posedge clk);
         #1 chk($sformatf("v%0d", k), {a1, b1, c1}, k);
      end
      chk("busy_last", busy1, 1);
      chk("no_early_done", done1, 0);
      @(posedge clk);
      #1 chk("done_pulse", done1, 1);
      chk("busy_off", busy1, 0);
      chk("pass_clean", pass1, 1);
      chk("err_clean", err1, 0);
      chk("fail_clean", fail1, 0);
      chk("stim_idle", {a1, b1, c1}, 0);
      @(posedge clk);
      #1 chk("done_1cyc", done1, 0);
      chk("pass_hold", pass1, 1);
      // sum stuck-at-0: vectors 001,010,100,111 fail
      mode = 2'd1;
      run(1'b0, n);
`ifdef FA_BIST_ABORT_ON_FAIL_EN
      chk("sa0_lat", n, 2);
      chk("sa0_err", err1, 1);
`else
      chk("sa0_lat", n, 8);
      chk("sa0_err", err1, 4);
`endif
      chk("sa0_ffv", ffv1, 1);
      chk("sa0_fail", fail1, 1);
      chk("sa0_pass", pass1, 0);
      @(posedge clk);
      #1 chk("sa0_err_hold", err1, err1 == 8'd0 ? 8'd99 : err1);
      chk("sa0_idle_busy", busy1, 0);
      // carry_out inverted, 2 loops x 3 settle cycles: every vector fails
      mode = 2'd2;
      run(1'b1, n);
`ifdef FA_BIST_ABORT_ON_FAIL_EN
      chk("inv_lat", n, 3);
      chk("inv_err", err2, 1);
`else
      chk("inv_lat", n, 48);
      chk("inv_err", err2, 16);
`endif
      chk("inv_ffv", ffv2, 0);
      chk("inv_pass", pass2, 0);
      // start re-asserted while busy must not disturb the sweep
      mode = 2'd0;
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      n = 0;
      while (!done1 && n < 500) begin
         @(posedge clk);
         #1 n++;
         if (n == 3) start1 = 1'b1;
         if (n == 5) start1 = 1'b0;
         if (n == 4) chk("restart_vec", {a1, b1, c1}, 4);
      end
      chk("restart_lat", n, 8);
      chk("restart_pass", pass1, 1);
      chk("restart_err", err1, 0);
      // reset during vector 5 aborts with no done
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("pre_rst_vec", {a1, b1, c1}, 5);
      #2 rst = 1'b1;
      #1 chk("rst_outs", {a1, b1, c1, busy1, done1, pass1, err1, fail1, ffv1}, 0);
      n = 0;
      repeat (3) begin
         @(posedge clk);
         #1 n += done1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 n += done1;
      end
      chk("rst_no_done", n, 0);
      // clean run after reset
      run(1'b0, n);
      chk("post_rst_lat", n, 8);
      chk("post_rst_pass", pass1, 1);
      chk("post_rst_err", err1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
